// File: rtl/ex_div_unit.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU in EX, with pipeline freeze handshake.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_div_unit #(
  parameter int STALL_W = 6,
  parameter int EX_BIT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  input  logic               cancel,
  input  logic [STALL_W-1:0] stall,
  output logic               stallreq_for_ex,
  output logic               div_busy,
  output logic               result_ready,
  output logic [31:0]        quotient,
  output logic [31:0]        remainder
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] divisor;
  logic [63:0] prem;
  logic        q_neg, r_neg;

  logic        sign_a, sign_b;
  logic [31:0] abs_a, abs_b;
  logic [63:0] shifted, prem_nxt;
  logic [32:0] diff;

  assign sign_a = div_signed & op_a[31];
  assign sign_b = div_signed & op_b[31];
  assign abs_a  = sign_a ? -op_a : op_a;
  assign abs_b  = sign_b ? -op_b : op_b;

  // Upper half is the running remainder, lower half collects quotient bits.
  always_comb begin
    shifted  = {prem[62:0], 1'b0};
    diff     = {1'b0, shifted[63:32]} - {1'b0, divisor};
    prem_nxt = shifted;
    if (!diff[32]) prem_nxt = {diff[31:0], shifted[31:1], 1'b1};
  end

  // Gated by rst so the freeze request is low while reset is held.
  assign stallreq_for_ex = rst & div_start & ~cancel & (state != DONE);
  assign div_busy        = (state == CALC);
  assign result_ready    = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      divisor   <= '0;
      prem      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      state   <= IDLE;
      count   <= '0;
      divisor <= '0;
      prem    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            q_neg   <= sign_a ^ sign_b;
            r_neg   <= sign_a;
            count   <= '0;
            divisor <= abs_b;
            prem    <= {32'd0, abs_a};
            if (op_b == 32'd0) begin
              quotient  <= 32'hFFFF_FFFF;
              remainder <= op_a;
              state     <= DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (abs_a < abs_b) begin
              quotient  <= 32'd0;
              remainder <= op_a;
              state     <= DONE;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem  <= prem_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            quotient  <= q_neg ? -prem_nxt[31:0]  : prem_nxt[31:0];
            remainder <= r_neg ? -prem_nxt[63:32] : prem_nxt[63:32];
            state     <= DONE;
          end
        end
        DONE: begin
          if (!stall[EX_BIT]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed vector bench for ex_div_unit: latency, stall handshake, sign cases, hold, cancel, reset.
module tb_ex_div_unit;
  localparam int STALL_W = 6;
  localparam int EX_BIT  = 2;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic div_start = 1'b0, div_signed = 1'b0, cancel = 1'b0, hold_ex = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [STALL_W-1:0] stall;
  logic stallreq_for_ex, div_busy, result_ready;
  logic [31:0] quotient, remainder;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  // Stall controller model: EX freezes on the request or on an external hold.
  always_comb begin
    stall         = '0;
    stall[EX_BIT] = stallreq_for_ex | hold_ex;
  end

  ex_div_unit #(.STALL_W(STALL_W), .EX_BIT(EX_BIT)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .op_a(op_a), .op_b(op_b), .cancel(cancel), .stall(stall),
    .stallreq_for_ex(stallreq_for_ex), .div_busy(div_busy),
    .result_ready(result_ready), .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a, b, q, r;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first result_ready cycle.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int sr_cnt);
    int cyc;
    div_signed = sg; op_a = a; op_b = b; div_start = 1'b1;
    cyc = 0; sr_cnt = 0;
    forever begin
      #1;
      if (stallreq_for_ex) sr_cnt++;
      if (result_ready || cyc >= 100) break;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
  endtask

  initial begin
    vec_t vt[10];
    int lat, src, cnt;
    logic [31:0] hq, hr;

    vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vt[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33};
    vt[2] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vt[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vt[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
    vt[5] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          EARLY_LAT};
    vt[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vt[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vt[8] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
    vt[9] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD,  EARLY_LAT};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset ready", {31'd0, result_ready}, 32'd0);
    chk("reset busy", {31'd0, div_busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors, issued back to back
    for (int i = 0; i < 10; i++) begin
      run_div(vt[i].sg, vt[i].a, vt[i].b, lat, src);
      chk($sformatf("v%0d latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d stallreq cycles", i), src, vt[i].lat);
      chk($sformatf("v%0d quotient", i), quotient, vt[i].q);
      chk($sformatf("v%0d remainder", i), remainder, vt[i].r);
      div_start = 1'b0;
      @(negedge clk);
    end

    // Result held for 3 extra stalled cycles, then back-to-back DIVU 9/3
    run_div(1'b0, 32'd50, 32'd8, lat, src);
    hold_ex = 1'b1;
    chk("hold quotient", quotient, 32'd6);
    chk("hold remainder", remainder, 32'd2);
    hq = quotient; hr = remainder;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d ready", k), {31'd0, result_ready}, 32'd1);
      chk($sformatf("hold%0d stallreq", k), {31'd0, stallreq_for_ex}, 32'd0);
      chk($sformatf("hold%0d q stable", k), quotient, hq);
      chk($sformatf("hold%0d r stable", k), remainder, hr);
    end
    hold_ex = 1'b0; div_start = 1'b0;
    @(negedge clk); #1;
    chk("after hold ready", {31'd0, result_ready}, 32'd0);
    run_div(1'b0, 32'd9, 32'd3, lat, src);
    chk("b2b latency", lat, 33);
    chk("b2b quotient", quotient, 32'd3);
    chk("b2b remainder", remainder, 32'd0);
    div_start = 1'b0;
    @(negedge clk);

    // Cancel at cycle 10
    div_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3; div_start = 1'b1;
    for (int c = 0; c < 10; c++) @(negedge clk);
    #1;
    chk("pre-cancel busy", {31'd0, div_busy}, 32'd1);
    chk("pre-cancel stallreq", {31'd0, stallreq_for_ex}, 32'd1);
    cancel = 1'b1; #1;
    chk("cancel stallreq drop", {31'd0, stallreq_for_ex}, 32'd0);
    @(negedge clk);
    cancel = 1'b0; div_start = 1'b0; #1;
    chk("cancel busy", {31'd0, div_busy}, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1; if (result_ready) cnt++;
      @(negedge clk);
    end
    chk("cancel never ready", cnt, 0);

    // Async reset at cycle 20 of a division; outputs still hold the 9/3 result
    chk("pre-reset quotient", quotient, 32'd3);
    op_a = 32'd1000; op_b = 32'd3; div_start = 1'b1;
    for (int c = 0; c < 20; c++) @(negedge clk);
    #1;
    chk("pre-reset busy", {31'd0, div_busy}, 32'd1);
    rst = 1'b0; #1;
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst busy", {31'd0, div_busy}, 32'd0);
    chk("rst ready", {31'd0, result_ready}, 32'd0);
    chk("rst stallreq", {31'd0, stallreq_for_ex}, 32'd0);
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
